collision_frame_detector: RTL and testbench
===========================================

# collision_frame_detector

Per-frame collision detector sitting downstream of the sprite bitmap blocks. It monitors the `drawingRequest` lines of up to `NUM_OBJECTS` sprites and flags any pixel where two or more sprites want to draw. On the first such pixel in a frame it emits a single-cycle pulse and latches the hit coordinates. At each `startOfFrame` it publishes the set of objects involved in collisions during the previous frame for the game-logic controllers.

## Interface
- `NUM_OBJECTS`, 4: number of sprite `drawingRequest` inputs (2..16).
- `PIPE_DELAY`, 1: register stages applied to `pixelX`/`pixelY` to align them with `drawingRequest`. Bitmap blocks register their output one clock after coordinates arrive.
- `COUNT_W`, 8: width of the saturating per-frame overlap counter.

Ports:
- `clk`  in  1  system pixel clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `startOfFrame`  in  1  one-cycle pulse at frame start.
- `pixelX`  in  11  current scan X.
- `pixelY`  in  11  current scan Y.
- `drawingRequest`  in  NUM_OBJECTS  per-sprite draw request, already one cycle behind `pixelX`/`pixelY`.
- `collisionPulse`  out  1  one-cycle pulse on the first overlap of a frame.
- `firstHitX`  out  11  aligned X of the first overlap in the current frame.
- `firstHitY`  out  11  aligned Y of the first overlap in the current frame.
- `objHit`  out  NUM_OBJECTS  objects involved in any overlap during the previous frame; held for the whole frame.
- `overlapCount`  out  COUNT_W  overlap pixels counted in the previous frame, saturating.

## Operation
- `overlap` = popcount(`drawingRequest`) >= 2. This term is combinational.
- FSM states:
  - ARMED: waiting for the first overlap of the frame.
  - HIT: an overlap has already been reported this frame.
- ARMED, overlap, not `startOfFrame` -> HIT. On that transition:
  - `collisionPulse` <= 1 for exactly one cycle.
  - `firstHitX`/`firstHitY` <= delayed `pixelX`/`pixelY`.
- HIT: further overlaps produce no pulse and leave `firstHitX`/`firstHitY` unchanged.
- Every overlap cycle in either state, unless `startOfFrame` is high:
  - `accFlags` |= `drawingRequest`.
  - `accCount` += 1, saturating at 2^COUNT_W-1.
- `startOfFrame` cycle:
  - `objHit` <= `accFlags`; `overlapCount` <= `accCount`.
  - Clear `accFlags` and `accCount`.
  - FSM -> ARMED.
  - `firstHitX`/`firstHitY` are held until the next first hit.
  - Overlap sampled on this cycle is ignored: no pulse, no accumulation.
- A single object requesting alone is never an overlap. All-ones `drawingRequest` is one overlap pixel and sets every `accFlags` bit.
- Reset, including mid-frame, clears all of the following and sets FSM to ARMED:
  - All outputs, which reset to 0.
  - `accFlags`, `accCount`.
  - The delay-line contents.

## Timing
- Overlap sampled at cycle N -> `collisionPulse` high at cycle N+1 (registered), with `firstHitX`/`firstHitY` valid that same cycle.
- Alignment: the coordinate reported for a `drawingRequest` sampled at cycle N is the `pixelX`/`pixelY` presented at cycle N-`PIPE_DELAY`.
- `objHit`/`overlapCount` update at cycle S+1 after a `startOfFrame` at cycle S, then stay constant until the next `startOfFrame`.
- At most one `collisionPulse` per frame. The next pulse is possible no earlier than the cycle after the following `startOfFrame`.
- Back-to-back `startOfFrame` cycles: each one publishes the current accumulator. The second publishes zeros.
- Throughput: one pixel per clock, no stalls.

## Structure
- Shared package `collision_pkg` holds:
  - FSM enum `coll_state_t` {ARMED, HIT}.
  - `PIXEL_W` = 11.
  - `COUNT_W` default.
- Sub-module `coord_delay_line`: parameterised `PIPE_DELAY`-stage register chain for {pixelX, pixelY}, synchronous active-high reset to 0. It is instantiated once.
- The popcount/overlap term and the FSM live in the top module.

## Test plan
- Reset, then `drawingRequest`=4'b0001 for a full frame, then `startOfFrame` -> no `collisionPulse`, `objHit`=0, `overlapCount`=0.
- Coordinates (100,50) presented, next cycle `drawingRequest`=4'b0101 -> `collisionPulse` 1 cycle later. `firstHitX`=100, `firstHitY`=50.
- Overlaps 4'b0011 at (10,10) and then 4'b1100 at (20,10) in one frame, then `startOfFrame` -> exactly one pulse. `firstHit`=(10,10), `objHit`=4'b1111, `overlapCount`=2.
- 300 overlap cycles in one frame -> `overlapCount`=255 after `startOfFrame`.
- Overlap coincident with `startOfFrame` -> no pulse. The published values exclude that cycle; the next frame starts ARMED with `accCount`=0.
- `reset` asserted mid-frame after a hit -> all outputs 0 next cycle. A subsequent overlap produces a pulse again.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and constants for the per-frame sprite collision detector.
// The popcount helper is sized for the widest supported object count.
package collision_pkg;

    typedef enum logic [0:0] {
        ARMED = 1'b0,
        HIT   = 1'b1
    } coll_state_t;

    localparam int PIXEL_W         = 11;
    localparam int COUNT_W_DEFAULT = 8;
    localparam int MAX_OBJECTS     = 16;

    function automatic logic [4:0] popcount16(input logic [MAX_OBJECTS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_OBJECTS; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/coord_delay_line.sv
// Register chain that lags {x, y} by PIPE_DELAY clocks so the coordinates line up
// with the registered drawingRequest coming out of the bitmap blocks.
module coord_delay_line
    import collision_pkg::*;
#(
    parameter int PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] x_in,
    input  logic [PIXEL_W-1:0] y_in,
    output logic [PIXEL_W-1:0] x_out,
    output logic [PIXEL_W-1:0] y_out
);

    generate
        if (PIPE_DELAY == 0) begin : g_bypass
            assign x_out = x_in;
            assign y_out = y_in;
        end else begin : g_chain
            logic [2*PIXEL_W-1:0] stages [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= {x_in, y_in};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign x_out = stages[PIPE_DELAY-1][2*PIXEL_W-1:PIXEL_W];
            assign y_out = stages[PIPE_DELAY-1][PIXEL_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/collision_frame_detector.sv
// Flags pixels where two or more sprites draw at once: one pulse plus coordinates on the
// first hit of a frame, and per-frame object/overlap summaries published at startOfFrame.
//
// state | meaning
// ARMED | no overlap reported yet in this frame
// HIT   | first overlap already reported; further overlaps only accumulate
module collision_frame_detector
    import collision_pkg::*;
#(
    parameter int NUM_OBJECTS = 4,
    parameter int PIPE_DELAY  = 1,
    parameter int COUNT_W     = COUNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [PIXEL_W-1:0]     pixelX,
    input  logic [PIXEL_W-1:0]     pixelY,
    input  logic [NUM_OBJECTS-1:0] drawingRequest,
    output logic                   collisionPulse,
    output logic [PIXEL_W-1:0]     firstHitX,
    output logic [PIXEL_W-1:0]     firstHitY,
    output logic [NUM_OBJECTS-1:0] objHit,
    output logic [COUNT_W-1:0]     overlapCount
);

    coll_state_t              state;
    logic [PIXEL_W-1:0]       x_aligned;
    logic [PIXEL_W-1:0]       y_aligned;
    logic [MAX_OBJECTS-1:0]   req_wide;
    logic [4:0]               req_count;
    logic                     overlap;
    logic [NUM_OBJECTS-1:0]   acc_flags;
    logic [COUNT_W-1:0]       acc_count;

    coord_delay_line #(
        .PIPE_DELAY(PIPE_DELAY)
    ) u_coord_delay (
        .clk   (clk),
        .reset (reset),
        .x_in  (pixelX),
        .y_in  (pixelY),
        .x_out (x_aligned),
        .y_out (y_aligned)
    );

    assign req_wide  = MAX_OBJECTS'(drawingRequest);
    assign req_count = popcount16(req_wide);
    assign overlap   = (req_count >= 5'd2);

    // startOfFrame wins over a coincident overlap: that pixel is neither reported nor counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARMED;
            collisionPulse <= 1'b0;
            firstHitX      <= '0;
            firstHitY      <= '0;
            objHit         <= '0;
            overlapCount   <= '0;
            acc_flags      <= '0;
            acc_count      <= '0;
        end else begin
            collisionPulse <= 1'b0;
            if (startOfFrame) begin
                objHit       <= acc_flags;
                overlapCount <= acc_count;
                acc_flags    <= '0;
                acc_count    <= '0;
                state        <= ARMED;
            end else if (overlap) begin
                acc_flags <= acc_flags | drawingRequest;
                if (acc_count != {COUNT_W{1'b1}}) begin
                    acc_count <= acc_count + COUNT_W'(1);
                end
                if (state == ARMED) begin
                    collisionPulse <= 1'b1;
                    firstHitX      <= x_aligned;
                    firstHitY      <= y_aligned;
                    state          <= HIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_frame_detector.sv
// Scoreboard bench for collision_frame_detector: each driven cycle pushes the
// expected post-edge outputs, which are popped and compared one time unit after the edge.
module tb_collision_frame_detector;

    logic        clk;
    logic        reset;
    logic        start_of_frame;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [3:0]  drawing_request;
    logic        collision_pulse;
    logic [10:0] first_hit_x;
    logic [10:0] first_hit_y;
    logic [3:0]  obj_hit;
    logic [7:0]  overlap_count;

    collision_frame_detector #(
        .NUM_OBJECTS(4),
        .PIPE_DELAY (1),
        .COUNT_W    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (start_of_frame),
        .pixelX        (pixel_x),
        .pixelY        (pixel_y),
        .drawingRequest(drawing_request),
        .collisionPulse(collision_pulse),
        .firstHitX     (first_hit_x),
        .firstHitY     (first_hit_y),
        .objHit        (obj_hit),
        .overlapCount  (overlap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pulse;
        logic [10:0] fx;
        logic [10:0] fy;
        logic [3:0]  obj;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    exp_t        m_out = '{pulse: 1'b0, fx: '0, fy: '0, obj: '0, cnt: '0};
    logic        m_reported = 1'b0;
    logic [3:0]  m_flags = '0;
    int          m_pixels = 0;
    logic [10:0] m_prev_x = '0;
    logic [10:0] m_prev_y = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic sof, input logic [10:0] x,
                        input logic [10:0] y, input logic [3:0] dr);
        exp_t e;
        reset           = rst;
        start_of_frame  = sof;
        pixel_x         = x;
        pixel_y         = y;
        drawing_request = dr;

        if (rst) begin
            m_out      = '{pulse: 1'b0, fx: '0, fy: '0, obj: '0, cnt: '0};
            m_reported = 1'b0;
            m_flags    = '0;
            m_pixels   = 0;
            m_prev_x   = '0;
            m_prev_y   = '0;
        end else begin
            m_out.pulse = 1'b0;
            if (sof) begin
                m_out.obj  = m_flags;
                m_out.cnt  = (m_pixels > 255) ? 8'd255 : 8'(m_pixels);
                m_flags    = '0;
                m_pixels   = 0;
                m_reported = 1'b0;
            end else if ($countones(dr) >= 2) begin
                m_flags  = m_flags | dr;
                m_pixels = m_pixels + 1;
                if (!m_reported) begin
                    m_out.pulse = 1'b1;
                    m_out.fx    = m_prev_x;
                    m_out.fy    = m_prev_y;
                    m_reported  = 1'b1;
                end
            end
            m_prev_x = x;
            m_prev_y = y;
        end
        e = m_out;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("pulse", {31'd0, collision_pulse}, {31'd0, e.pulse});
            chk("first_x", {21'd0, first_hit_x}, {21'd0, e.fx});
            chk("first_y", {21'd0, first_hit_y}, {21'd0, e.fy});
            chk("obj_hit", {28'd0, obj_hit}, {28'd0, e.obj});
            chk("ovl_cnt", {24'd0, overlap_count}, {24'd0, e.cnt});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 11'(i), 11'd7, 4'b0000);
    endtask

    initial begin
        reset = 1'b1; start_of_frame = 1'b0;
        pixel_x = '0; pixel_y = '0; drawing_request = '0;

        // reset state
        step(1'b1, 1'b0, 11'd5, 11'd5, 4'b1111);
        step(1'b1, 1'b0, 11'd6, 11'd6, 4'b1111);
        chk("rst_pulse", {31'd0, collision_pulse}, 32'd0);
        chk("rst_obj", {28'd0, obj_hit}, 32'd0);

        // lone sprite for a whole frame is never an overlap
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0000);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 11'(i), 11'd3, 4'b0001);
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0001);
        chk("solo_obj", {28'd0, obj_hit}, 32'd0);
        chk("solo_cnt", {24'd0, overlap_count}, 32'd0);

        // coordinates one cycle ahead of the request
        step(1'b0, 1'b0, 11'd100, 11'd50, 4'b0000);
        step(1'b0, 1'b0, 11'd200, 11'd60, 4'b0101);
        chk("hit_pulse", {31'd0, collision_pulse}, 32'd1);
        chk("hit_x", {21'd0, first_hit_x}, 32'd100);
        chk("hit_y", {21'd0, first_hit_y}, 32'd50);
        idle(3);

        // two overlaps in one frame, only the first is reported
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0000);
        step(1'b0, 1'b0, 11'd10, 11'd10, 4'b0000);
        step(1'b0, 1'b0, 11'd20, 11'd10, 4'b0011);
        step(1'b0, 1'b0, 11'd30, 11'd10, 4'b1100);
        chk("second_no_pulse", {31'd0, collision_pulse}, 32'd0);
        idle(4);
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0000);
        chk("two_obj", {28'd0, obj_hit}, 32'hF);
        chk("two_cnt", {24'd0, overlap_count}, 32'd2);
        chk("two_x", {21'd0, first_hit_x}, 32'd10);
        chk("two_y", {21'd0, first_hit_y}, 32'd10);

        // saturation
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 11'(i), 11'd99, 4'b1111);
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0000);
        chk("sat_cnt", {24'd0, overlap_count}, 32'd255);
        chk("sat_obj", {28'd0, obj_hit}, 32'hF);

        // overlap coincident with startOfFrame, and back-to-back frame starts
        step(1'b0, 1'b0, 11'd40, 11'd41, 4'b0110);
        step(1'b0, 1'b1, 11'd42, 11'd43, 4'b0011);
        chk("sof_obj", {28'd0, obj_hit}, 32'h6);
        chk("sof_cnt", {24'd0, overlap_count}, 32'd1);
        step(1'b0, 1'b1, 11'd44, 11'd45, 4'b1001);
        chk("sof2_cnt", {24'd0, overlap_count}, 32'd0);
        step(1'b0, 1'b1, 11'd46, 11'd47, 4'b0000);
        chk("sof3_obj", {28'd0, obj_hit}, 32'd0);
        step(1'b0, 1'b0, 11'd48, 11'd49, 4'b1010);
        chk("rearm_pulse", {31'd0, collision_pulse}, 32'd1);
        chk("rearm_x", {21'd0, first_hit_x}, 32'd46);

        // mid-frame reset after a hit
        idle(2);
        step(1'b1, 1'b0, 11'd9, 11'd9, 4'b1111);
        chk("mid_rst_x", {21'd0, first_hit_x}, 32'd0);
        chk("mid_rst_cnt", {24'd0, overlap_count}, 32'd0);
        step(1'b0, 1'b0, 11'd77, 11'd88, 4'b0000);
        step(1'b0, 1'b0, 11'd1, 11'd2, 4'b1001);
        chk("post_rst_pulse", {31'd0, collision_pulse}, 32'd1);
        chk("post_rst_x", {21'd0, first_hit_x}, 32'd77);

        // random traffic with occasional frame starts
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 39) == 0), 11'($urandom_range(0, 2047)),
                 11'($urandom_range(0, 2047)), 4'($urandom_range(0, 15)));
        end
        step(1'b0, 1'b1, 11'd0, 11'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
